// File: rtl/uart_packet_builder.sv
// uart_packet_builder: frames ADS samples and ADS/MPR register reads into 56-bit packets,
// arbitrates them into a small FIFO and hands them to the UART controller over valid/ready.
module uart_packet_builder #(
  parameter int          FIFO_AW      = 2,
  parameter logic [7:0]  HDR_ADS_DATA = 8'hAA,
  parameter logic [7:0]  HDR_ADS_REG  = 8'h61,
  parameter logic [7:0]  HDR_MPR_REG  = 8'h6D
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_CLR,
  input  logic [23:0]        i_ADS_DATA_CH1,
  input  logic [23:0]        i_ADS_DATA_CH2,
  input  logic               i_ADS_DATA_VALID,
  input  logic [7:0]         i_ADS_REG_ADDR,
  input  logic [7:0]         i_ADS_REG_DATA,
  input  logic               i_ADS_REG_VALID,
  input  logic [7:0]         i_MPR_REG_ADDR,
  input  logic [7:0]         i_MPR_REG_DATA,
  input  logic               i_MPR_REG_VALID,
  output logic [55:0]        o_UART_DATA_TX,
  output logic               o_UART_DATA_TX_VALID,
  input  logic               i_UART_DATA_TX_READY,
  output logic [FIFO_AW:0]   o_FIFO_LEVEL,
  output logic [7:0]         o_DROP_CNT,
  output logic               o_OVERFLOW
);
  localparam int DEPTH = 2 ** FIFO_AW;
  logic [55:0]      r_mem [DEPTH];
  logic [FIFO_AW:0] r_wr_ptr, r_rd_ptr;
  logic [55:0]      r_dat_pkt, r_areg_pkt, r_mreg_pkt;
  logic             r_dat_pend, r_areg_pend, r_mreg_pend;
  logic [7:0]       r_drop_cnt;
  logic             r_overflow;
  logic             w_full, w_empty, w_push, w_pop, w_drop;
  logic             w_sel_m, w_sel_a, w_sel_d;
  logic [55:0]      w_push_pkt;
  always_comb begin
    w_full     = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                 (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    w_empty    = r_wr_ptr == r_rd_ptr;
    w_sel_m    = r_mreg_pend && !w_full;
    w_sel_a    = r_areg_pend && !r_mreg_pend && !w_full;
    w_sel_d    = r_dat_pend && !r_areg_pend && !r_mreg_pend && !w_full;
    w_push     = w_sel_m || w_sel_a || w_sel_d;
    w_push_pkt = w_sel_m ? r_mreg_pkt : w_sel_a ? r_areg_pkt : r_dat_pkt;
    w_pop      = !w_empty && i_UART_DATA_TX_READY;
    // a pending packet being moved out on this edge frees its slot, so a new valid is not a loss
    w_drop     = !i_CLR && ((i_ADS_DATA_VALID && r_dat_pend && !w_sel_d) ||
                            (i_ADS_REG_VALID && r_areg_pend && !w_sel_a) ||
                            (i_MPR_REG_VALID && r_mreg_pend && !w_sel_m));
  end
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_dat_pkt   <= '0;
      r_areg_pkt  <= '0;
      r_mreg_pkt  <= '0;
      r_dat_pend  <= 1'b0;
      r_areg_pend <= 1'b0;
      r_mreg_pend <= 1'b0;
    end else if (i_CLR) begin
      r_dat_pend  <= 1'b0;
      r_areg_pend <= 1'b0;
      r_mreg_pend <= 1'b0;
    end else begin
      if (i_ADS_DATA_VALID) begin
        r_dat_pkt  <= {HDR_ADS_DATA, i_ADS_DATA_CH1, i_ADS_DATA_CH2};
        r_dat_pend <= 1'b1;
      end else if (w_sel_d) r_dat_pend <= 1'b0;
      if (i_ADS_REG_VALID) begin
        r_areg_pkt  <= {HDR_ADS_REG, i_ADS_REG_ADDR, i_ADS_REG_DATA, 32'h0};
        r_areg_pend <= 1'b1;
      end else if (w_sel_a) r_areg_pend <= 1'b0;
      if (i_MPR_REG_VALID) begin
        r_mreg_pkt  <= {HDR_MPR_REG, i_MPR_REG_ADDR, i_MPR_REG_DATA, 32'h0};
        r_mreg_pend <= 1'b1;
      end else if (w_sel_m) r_mreg_pend <= 1'b0;
    end
  end
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_CLR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[FIFO_AW-1:0]] <= w_push_pkt;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      r_drop_cnt <= '0;
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_drop_cnt <= (r_drop_cnt == 8'hFF) ? r_drop_cnt : r_drop_cnt + 8'd1;
      r_overflow <= 1'b1;
    end
  end
  assign o_UART_DATA_TX       = r_mem[r_rd_ptr[FIFO_AW-1:0]];
  assign o_UART_DATA_TX_VALID = !w_empty;
  assign o_FIFO_LEVEL         = r_wr_ptr - r_rd_ptr;
  assign o_DROP_CNT           = r_drop_cnt;
  assign o_OVERFLOW           = r_overflow;
endmodule

// File: tb/tb_uart_packet_builder.sv
// tb_uart_packet_builder: queue-based reference model with a negedge monitor that
// consumes expected packets whenever the controller side would pop.
module tb_uart_packet_builder;
  logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, ready = 1'b0;
  logic [23:0] ch1 = '0, ch2 = '0;
  logic        ads_valid = 1'b0, areg_valid = 1'b0, mreg_valid = 1'b0;
  logic [7:0]  areg_addr = '0, areg_data = '0, mreg_addr = '0, mreg_data = '0;
  logic [55:0] tx;
  logic        tx_valid, ovf;
  logic [2:0]  level;
  logic [7:0]  drop_cnt;
  int          n_chk = 0, n_fail = 0;
  logic [55:0] m_fifo[$];
  bit          m_pend[3];
  logic [55:0] m_pkt[3];
  int          m_drop = 0;
  bit          m_ovf = 0, popped = 0;

  uart_packet_builder dut (
    .i_CLK(clk), .i_RST(rst), .i_CLR(clr),
    .i_ADS_DATA_CH1(ch1), .i_ADS_DATA_CH2(ch2), .i_ADS_DATA_VALID(ads_valid),
    .i_ADS_REG_ADDR(areg_addr), .i_ADS_REG_DATA(areg_data), .i_ADS_REG_VALID(areg_valid),
    .i_MPR_REG_ADDR(mreg_addr), .i_MPR_REG_DATA(mreg_data), .i_MPR_REG_VALID(mreg_valid),
    .o_UART_DATA_TX(tx), .o_UART_DATA_TX_VALID(tx_valid), .i_UART_DATA_TX_READY(ready),
    .o_FIFO_LEVEL(level), .o_DROP_CNT(drop_cnt), .o_OVERFLOW(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: three one-slot mailboxes feeding a 4-entry queue
  always @(posedge clk or posedge rst) begin : model
    int sz;
    bit moved, drop;
    bit v[3];
    logic [55:0] nw[3];
    if (rst) begin
      m_fifo.delete();
      m_pend = '{default: 0};
      m_drop = 0;
      m_ovf  = 0;
      popped = 0;
    end else begin
      sz = m_fifo.size() + int'(popped);
      popped = 0;
      if (clr) begin
        m_fifo.delete();
        m_pend = '{default: 0};
      end else begin
        nw = '{{8'h6D, mreg_addr, mreg_data, 32'h0}, {8'h61, areg_addr, areg_data, 32'h0},
               {8'hAA, ch1, ch2}};
        v = '{mreg_valid, areg_valid, ads_valid};
        moved = 0;
        for (int s = 0; s < 3; s++)
          if (!moved && m_pend[s] && sz < 4) begin
            m_fifo.push_back(m_pkt[s]);
            m_pend[s] = 0;
            moved = 1;
          end
        drop = 0;
        for (int s = 0; s < 3; s++)
          if (v[s]) begin
            if (m_pend[s]) drop = 1;
            m_pkt[s]  = nw[s];
            m_pend[s] = 1;
          end
        if (drop) begin
          if (m_drop < 255) m_drop++;
          m_ovf = 1;
        end
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("tx_valid", tx_valid, m_fifo.size() != 0);
    chk("fifo_level", level, m_fifo.size());
    chk("drop_cnt", drop_cnt, m_drop);
    chk("overflow", ovf, m_ovf);
    if (m_fifo.size() != 0) begin
      chk("tx_data", tx, m_fifo[0]);
      if (ready) begin
        void'(m_fifo.pop_front());
        popped = 1;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ads_pulse(logic [23:0] a, logic [23:0] b);
    ch1 = a; ch2 = b; ads_valid = 1'b1;
    tick();
    ads_valid = 1'b0;
  endtask

  task automatic rand_phase(int cycles, int ready_pct);
    for (int c = 0; c < cycles; c++) begin
      ads_valid  = $urandom_range(0, 3) == 0;
      areg_valid = $urandom_range(0, 5) == 0;
      mreg_valid = $urandom_range(0, 5) == 0;
      ch1 = 24'($urandom); ch2 = 24'($urandom);
      areg_addr = 8'($urandom); areg_data = 8'($urandom);
      mreg_addr = 8'($urandom); mreg_data = 8'($urandom);
      ready = $urandom_range(0, 99) < ready_pct;
      clr   = $urandom_range(0, 79) == 0;
      tick();
    end
    {ads_valid, areg_valid, mreg_valid, clr} = '0;
  endtask

  initial begin
    tick(2);
    chk("reset_valid", tx_valid, 0);
    chk("reset_tx", tx, 0);
    chk("reset_level", level, 0);
    rst = 1'b0;
    tick();
    // single ADS sample, visible two cycles after the pulse edge
    ready = 1'b1;
    ads_pulse(24'h123456, 24'hABCDEF);
    tick();
    @(negedge clk);
    chk("ads_latency_valid", tx_valid, 1);
    chk("ads_packet", tx, 56'hAA123456ABCDEF);
    tick(3);
    chk("ads_drained_level", level, 0);
    // simultaneous register reads: MPR outranks ADS
    areg_addr = 8'h01; areg_data = 8'h55; areg_valid = 1'b1;
    mreg_addr = 8'h02; mreg_data = 8'h66; mreg_valid = 1'b1;
    tick();
    {areg_valid, mreg_valid} = '0;
    tick(6);
    chk("no_drop_after_regs", drop_cnt, 0);
    // overrun with the controller stalled
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ads_pulse(24'(i + 1), 24'($urandom));
      tick();
    end
    chk("overrun_level", level, 4);
    chk("overrun_drop", drop_cnt, 1);
    chk("overrun_sticky", ovf, 1);
    ready = 1'b1;
    tick(8);
    chk("overrun_drained", level, 0);
    // toggled ready while draining four packets
    ready = 1'b0;
    for (int i = 0; i < 4; i++) ads_pulse(24'($urandom), 24'($urandom));
    tick(2);
    for (int i = 0; i < 12; i++) begin
      ready = ~ready;
      tick();
    end
    ready = 1'b0;
    // flush with three packets queued
    for (int i = 0; i < 3; i++) ads_pulse(24'($urandom), 24'($urandom));
    tick(2);
    chk("pre_flush_level", level, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("flush_valid", tx_valid, 0);
    chk("flush_level", level, 0);
    chk("flush_keeps_drop", drop_cnt, 1);
    ready = 1'b1;
    ads_pulse(24'h00C0DE, 24'hBEEF00);
    tick(4);
    // asynchronous reset while packets are queued
    ready = 1'b0;
    for (int i = 0; i < 3; i++) ads_pulse(24'($urandom), 24'($urandom));
    tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", tx_valid, 0);
    chk("async_rst_tx", tx, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_drop", drop_cnt, 0);
    chk("async_rst_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    tick();
    rand_phase(1500, 80);
    rand_phase(1500, 10);
    ready = 1'b1;
    tick(12);
    chk("final_drained", level, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
